icache_refill: RTL and testbench
================================

ICACHE_REFILL -- requirements
Module: icache_refill

Interface
REQ-001 SHALL have parameter WORD_SIZE, 16, data and address width in bits.
REQ-002 SHALL have parameter NUM_LINES, 8, number of direct-mapped lines (power of two).
REQ-003 SHALL have parameter LINE_WORDS, 4, words per line (power of two).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port cpu_req  input  1  CPU instruction fetch request.
REQ-007 SHALL have port cpu_addr  input  WORD_SIZE  fetch word address.
REQ-008 SHALL have port cpu_flush  input  1  invalidate all lines.
REQ-009 SHALL have port cpu_rdata  output  WORD_SIZE  fetched instruction word.
REQ-010 SHALL have port cpu_ready  output  1  cpu_rdata valid this cycle.
REQ-011 SHALL have port i_readM  output  1  memory instruction-port read enable.
REQ-012 SHALL have port i_writeM  output  1  memory instruction-port write enable, constant 0.
REQ-013 SHALL have port i_address  output  WORD_SIZE  memory word address.
REQ-014 SHALL have port i_data  input  WORD_SIZE  memory read data, valid the cycle after the address is presented with i_readM high, only while i_readM is high.

Function
REQ-015 SHALL split cpu_addr into tag [WORD_SIZE-1:log2(NUM_LINES*LINE_WORDS)], index, offset [log2(LINE_WORDS)-1:0].
REQ-016 SHALL run FSM IDLE -> FILL -> IDLE; hit = IDLE & valid[index] & tag match.
REQ-017 SHALL drive cpu_ready = cpu_req & hit combinationally, with cpu_rdata = stored word at index/offset; cpu_rdata otherwise holds its last value.
REQ-018 SHALL on cpu_req & !hit in IDLE latch line base address (offset zeroed) and enter FILL at the next edge.
REQ-019 SHALL in FILL hold i_readM = 1 for exactly LINE_WORDS+1 cycles, presenting base+0 .. base+LINE_WORDS-1 on consecutive cycles, then holding base+LINE_WORDS-1 in the final cycle.
REQ-020 SHALL capture i_data into word k of the line in FILL cycle k+1, k = 0..LINE_WORDS-1.
REQ-021 SHALL at the end of the last FILL cycle write tag, set valid and return to IDLE; miss-to-cpu_ready latency is LINE_WORDS+2 cycles (6 at default) counted from the missing request cycle as cycle 0.
REQ-022 SHALL drive i_readM = 0 and cpu_ready = 0 in IDLE and in FILL respectively; i_address = 0 in IDLE.
REQ-023 SHALL refill only the latched address; a cpu_addr change during FILL is re-evaluated in IDLE afterwards.
REQ-024 SHALL on cpu_flush clear all valid bits at the next edge; flush in FILL aborts the fill (no valid set), returns to IDLE, cpu_ready = 0 that cycle.
REQ-025 SHALL let cpu_flush take priority over a same-cycle hit or miss (no ready, no fill start).

Reset
REQ-026 SHALL on reset_n low immediately force IDLE, all valid bits 0, cpu_rdata 0, i_readM 0, i_address 0, counters 0; reset mid-FILL discards the partial line.
REQ-027 SHALL not reset tag or data arrays.

Configuration
REQ-028 SHALL with ICACHE_STATS_EN defined add outputs hit_count and miss_count (WORD_SIZE each): hit_count +1 per cpu_ready cycle, miss_count +1 per IDLE->FILL, both saturating at all-ones; true hits = hit_count - miss_count.
REQ-029 SHALL without ICACHE_STATS_EN omit those ports and counters entirely.

Structure
REQ-030 SHALL place FSM state typedef, default WORD_SIZE/NUM_LINES/LINE_WORDS constants and address-field width helpers in shared package icache_pkg.
REQ-031 SHALL implement the FILL address/capture counter as sub-module icache_fill_ctr; tag/data arrays stay in icache_refill.

Verification
REQ-032 Cold miss: mem[0x20..0x23] = 0x0000,0x0000,0x0000,0x6000, cpu_req addr 0x0023 -> i_readM high 5 cycles, addresses 0x20,0x21,0x22,0x23,0x23, cpu_ready in cycle 6 with cpu_rdata 0x6000.
REQ-033 Hit after fill: addr 0x0020 next cycle -> cpu_ready same cycle, 0x0000, i_readM stays 0.
REQ-034 Conflict: addr 0x0000 (mem 0x9023) then 0x0100 (same index, new tag) then 0x0000 -> three refills, cpu_rdata 0x9023 on the last.
REQ-035 Flush during FILL at cycle 3 -> IDLE next edge, line stays invalid, repeat request refills (5 i_readM cycles).
REQ-036 reset_n low mid-FILL -> i_readM 0 immediately, same address misses after release.
REQ-037 With ICACHE_STATS_EN: REQ-032 then REQ-033 -> hit_count 2, miss_count 1.

Source files
------------

// File: rtl/icache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : icache_pkg                                             |
// | Description : Shared types, default geometry and address-field       |
// |               width helpers for the instruction-cache refill block.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package icache_pkg;

  localparam int c_DEF_WORD_SIZE  = 16;
  localparam int c_DEF_NUM_LINES  = 8;
  localparam int c_DEF_LINE_WORDS = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fill_state_t;

  // Width of the word-offset field inside a line.
  function automatic int off_width(input int line_words);
    return $clog2(line_words);
  endfunction

  // Width of the line-index field.
  function automatic int idx_width(input int num_lines);
    return $clog2(num_lines);
  endfunction

  // Width of the tag: everything above index and offset.
  function automatic int tag_width(input int word_size, input int num_lines,
                                   input int line_words);
    return word_size - $clog2(num_lines * line_words);
  endfunction

endpackage
`default_nettype wire

// File: rtl/icache_refill_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : icache_refill_if                                       |
// | Description : CPU fetch port plus memory instruction port of the     |
// |               refill cache. slave = cache side, master = environment.|
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface icache_refill_if
  import icache_pkg::*;
#(
  parameter int WORD_SIZE = c_DEF_WORD_SIZE
);

  logic                 cpu_req;
  logic [WORD_SIZE-1:0] cpu_addr;
  logic                 cpu_flush;
  logic [WORD_SIZE-1:0] cpu_rdata;
  logic                 cpu_ready;
  logic                 i_readM;
  logic                 i_writeM;
  logic [WORD_SIZE-1:0] i_address;
  logic [WORD_SIZE-1:0] i_data;

  modport slave (
    input  cpu_req, cpu_addr, cpu_flush, i_data,
    output cpu_rdata, cpu_ready, i_readM, i_writeM, i_address
  );

  modport master (
    output cpu_req, cpu_addr, cpu_flush, i_data,
    input  cpu_rdata, cpu_ready, i_readM, i_writeM, i_address
  );

endinterface
`default_nettype wire

// File: rtl/icache_fill_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : icache_fill_ctr                                        |
// | Description : Cycle counter for one line refill. Produces the word   |
// |               offset to present to memory, the capture slot for the  |
// |               returning data and the last-cycle flag.                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module icache_fill_ctr
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = c_DEF_LINE_WORDS
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             advance,
  output logic [off_width(LINE_WORDS)-1:0] word_off,
  output logic                             cap_en,
  output logic [off_width(LINE_WORDS)-1:0] cap_idx,
  output logic                             last
);

  localparam int                 c_OFF_W   = off_width(LINE_WORDS);
  localparam int                 c_CNT_W   = c_OFF_W + 1;
  localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(LINE_WORDS);
  localparam logic [c_OFF_W-1:0] c_OFF_MAX = c_OFF_W'(LINE_WORDS - 1);

  // Counts FILL cycles 0..LINE_WORDS; any cycle without advance parks it at 0.
  logic [c_CNT_W-1:0] r_cnt;

  // Step through the refill window, wrapping to 0 after the last cycle or on abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (advance && !last) begin
      r_cnt <= r_cnt + c_CNT_W'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  assign last     = (r_cnt == c_LAST);
  // The extra final cycle keeps presenting the last word of the line.
  assign word_off = last ? c_OFF_MAX : r_cnt[c_OFF_W-1:0];
  // Data for the address shown in cycle k arrives in cycle k+1.
  assign cap_en   = (r_cnt != '0);
  assign cap_idx  = r_cnt[c_OFF_W-1:0] - c_OFF_W'(1);

endmodule
`default_nettype wire

// File: rtl/icache_refill.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : icache_refill                                          |
// | Description : Direct-mapped instruction cache with whole-line        |
// |               refill from a one-cycle-latency memory port.           |
// |               Define ICACHE_STATS_EN to add saturating hit_count /   |
// |               miss_count outputs.                                    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module icache_refill
  import icache_pkg::*;
#(
  parameter int WORD_SIZE  = c_DEF_WORD_SIZE,
  parameter int NUM_LINES  = c_DEF_NUM_LINES,
  parameter int LINE_WORDS = c_DEF_LINE_WORDS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  icache_refill_if.slave       bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [WORD_SIZE-1:0] hit_count,
  output logic [WORD_SIZE-1:0] miss_count
`endif
);

  localparam int c_OFF_W  = off_width(LINE_WORDS);
  localparam int c_IDX_W  = idx_width(NUM_LINES);
  localparam int c_TAG_W  = tag_width(WORD_SIZE, NUM_LINES, LINE_WORDS);
  localparam int c_LINE_W = WORD_SIZE - c_OFF_W;

  // Storage: tags and words are never reset, only the valid bits are.
  logic [c_TAG_W-1:0]   r_tag  [NUM_LINES];
  logic [WORD_SIZE-1:0] r_data [NUM_LINES*LINE_WORDS];
  logic [NUM_LINES-1:0] r_valid;

  fill_state_t          r_state;
  fill_state_t          w_state_next;
  logic [c_LINE_W-1:0]  r_base_line;
  logic [WORD_SIZE-1:0] r_rdata;

  logic [c_TAG_W-1:0]   w_cpu_tag;
  logic [c_IDX_W-1:0]   w_cpu_idx;
  logic [c_TAG_W-1:0]   w_base_tag;
  logic [c_IDX_W-1:0]   w_base_idx;
  logic [WORD_SIZE-1:0] w_rd_word;
  logic                 w_hit;
  logic                 w_ready;
  logic                 w_miss_start;
  logic                 w_fill_done;
  logic                 w_fill_write;
  logic                 w_advance;
  logic                 w_readM;
  logic [WORD_SIZE-1:0] w_address;
  logic [c_OFF_W-1:0]   w_word_off;
  logic [c_OFF_W-1:0]   w_cap_idx;
  logic                 w_cap_en;
  logic                 w_last;

  assign w_cpu_tag  = bus.cpu_addr[WORD_SIZE-1 -: c_TAG_W];
  assign w_cpu_idx  = bus.cpu_addr[c_OFF_W +: c_IDX_W];
  assign w_base_tag = r_base_line[c_LINE_W-1 -: c_TAG_W];
  assign w_base_idx = r_base_line[c_IDX_W-1:0];
  assign w_rd_word  = r_data[bus.cpu_addr[c_IDX_W+c_OFF_W-1:0]];

  // Lookup is only meaningful while idle; flush suppresses both hit and miss.
  assign w_hit        = (r_state == ST_IDLE) && r_valid[w_cpu_idx]
                        && (r_tag[w_cpu_idx] == w_cpu_tag);
  assign w_ready      = bus.cpu_req && w_hit && !bus.cpu_flush;
  assign w_miss_start = (r_state == ST_IDLE) && bus.cpu_req && !w_hit
                        && !bus.cpu_flush;
  assign w_fill_write = (r_state == ST_FILL) && !bus.cpu_flush;
  assign w_fill_done  = w_fill_write && w_last;

  icache_fill_ctr #(
    .LINE_WORDS (LINE_WORDS)
  ) u_fill_ctr (
    .clk      (clk),
    .reset_n  (reset_n),
    .advance  (w_advance),
    .word_off (w_word_off),
    .cap_en   (w_cap_en),
    .cap_idx  (w_cap_idx),
    .last     (w_last)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and memory-port drive: idle keeps the port quiet, fill streams the line.
  always_comb begin
    w_state_next = r_state;
    w_advance    = 1'b0;
    w_readM      = 1'b0;
    w_address    = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_miss_start) begin
          w_state_next = ST_FILL;
        end
      end
      ST_FILL: begin
        w_readM   = 1'b1;
        w_address = {r_base_line, w_word_off};
        if (bus.cpu_flush) begin
          w_state_next = ST_IDLE;
        end else begin
          w_advance = 1'b1;
          if (w_last) begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Latch the missing line address; later cpu_addr changes do not redirect the fill.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_base_line <= '0;
    end else if (w_miss_start) begin
      r_base_line <= bus.cpu_addr[WORD_SIZE-1:c_OFF_W];
    end
  end

  // Valid bits: flush wins over a completing fill so an aborted line never goes valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
    end else if (bus.cpu_flush) begin
      r_valid <= '0;
    end else if (w_fill_done) begin
      r_valid[w_base_idx] <= 1'b1;
    end
  end

  // Tag and data arrays written during refill; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_fill_write && w_cap_en) begin
      r_data[{w_base_idx, w_cap_idx}] <= bus.i_data;
    end
    if (w_fill_done) begin
      r_tag[w_base_idx] <= w_base_tag;
    end
  end

  // Remember the last delivered word so cpu_rdata holds between hits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= '0;
    end else if (w_ready) begin
      r_rdata <= w_rd_word;
    end
  end

  assign bus.cpu_ready = w_ready;
  assign bus.cpu_rdata = w_ready ? w_rd_word : r_rdata;
  assign bus.i_readM   = w_readM;
  assign bus.i_writeM  = 1'b0;
  assign bus.i_address = w_address;

`ifdef ICACHE_STATS_EN
  logic [WORD_SIZE-1:0] r_hit_count;
  logic [WORD_SIZE-1:0] r_miss_count;

  // Saturating event counters: every ready cycle, every refill start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_ready && (r_hit_count != '1)) begin
        r_hit_count <= r_hit_count + WORD_SIZE'(1);
      end
      if (w_miss_start && (r_miss_count != '1)) begin
        r_miss_count <= r_miss_count + WORD_SIZE'(1);
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_refill.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_icache_refill                                       |
// | Description : Self-checking bench for icache_refill: directed        |
// |               scenarios plus randomized fetches against a line-level |
// |               cache model and a flat memory image.                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_icache_refill;

  localparam int c_WS = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  icache_refill_if #(.WORD_SIZE(c_WS)) bus ();

`ifdef ICACHE_STATS_EN
  logic [c_WS-1:0] hit_count;
  logic [c_WS-1:0] miss_count;
`endif

  icache_refill #(
    .WORD_SIZE  (c_WS),
    .NUM_LINES  (8),
    .LINE_WORDS (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  // Memory: data returns the cycle after the address, only while i_readM is high.
  logic [c_WS-1:0] mem [0:65535];
  logic [c_WS-1:0] mem_q;
  always @(posedge clk) mem_q <= mem[bus.i_address];
  assign bus.i_data = bus.i_readM ? mem_q : 16'h0000;

  // Every address presented to memory, in order.
  logic [c_WS-1:0] q_addr [$];
  always @(negedge clk) if (bus.i_readM === 1'b1) q_addr.push_back(bus.i_address);

  // Line-level model: 8 lines of 4 words, line = addr/4, index = line%8, tag = addr/32.
  bit          m_valid [8];
  int unsigned m_tag   [8];
  int          m_hits;
  int          m_miss;

  int n_total = 0;
  int n_bad   = 0;

  function automatic int unsigned idx_of(int unsigned a);
    return (a / 4) % 8;
  endfunction

  function automatic int unsigned tag_of(int unsigned a);
    return a / 32;
  endfunction

  task automatic model_clear();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
  endtask

  task automatic model_fill(input int unsigned a);
    m_valid[idx_of(a)] = 1'b1;
    m_tag[idx_of(a)]   = tag_of(a);
  endtask

  // Hold a request until cpu_ready (bounded); reports latency (-1 on timeout) and data.
  task automatic run_fetch(input logic [c_WS-1:0] a, output int lat, output logic [c_WS-1:0] data);
    q_addr.delete();
    bus.cpu_addr = a;
    bus.cpu_req  = 1'b1;
    lat  = -1;
    data = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.cpu_ready === 1'b1) begin
        lat  = c;
        data = bus.cpu_rdata;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat >= 0) begin
      @(posedge clk); #1;
    end
    bus.cpu_req = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++; if (bus.cpu_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got=%b exp=0", bus.cpu_ready); end
    n_total++; if (bus.i_readM !== 1'b0) begin n_bad++; $display("FAIL reset_readM got=%b exp=0", bus.i_readM); end
    n_total++; if (bus.i_address !== 16'h0) begin n_bad++; $display("FAIL reset_addr got=%h exp=0000", bus.i_address); end
    n_total++; if (bus.cpu_rdata !== 16'h0) begin n_bad++; $display("FAIL reset_rdata got=%h exp=0000", bus.cpu_rdata); end
    n_total++; if (bus.i_writeM !== 1'b0) begin n_bad++; $display("FAIL reset_writeM got=%b exp=0", bus.i_writeM); end
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 16'h0023;
    @(posedge clk); @(negedge clk);
    n_total++; if (bus.i_readM !== 1'b0) begin n_bad++; $display("FAIL reset_req_readM got=%b exp=0", bus.i_readM); end
`ifdef ICACHE_STATS_EN
    n_total++; if (hit_count !== 16'h0 || miss_count !== 16'h0) begin n_bad++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", hit_count, miss_count); end
`endif
    bus.cpu_req = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_clear();
    m_hits = 0;
    m_miss = 0;
  endtask

  task automatic test_cold_miss();
    int lat;
    logic [c_WS-1:0] data;
    logic [c_WS-1:0] exp_a [5];
    exp_a = '{16'h20, 16'h21, 16'h22, 16'h23, 16'h23};
    mem[16'h20] = 16'h0000; mem[16'h21] = 16'h0000;
    mem[16'h22] = 16'h0000; mem[16'h23] = 16'h6000;
    run_fetch(16'h0023, lat, data);
    n_total++; if (lat !== 6) begin n_bad++; $display("FAIL cold_latency got=%0d exp=6", lat); end
    n_total++; if (data !== 16'h6000) begin n_bad++; $display("FAIL cold_data got=%h exp=6000", data); end
    n_total++; if (q_addr.size() !== 5) begin n_bad++; $display("FAIL cold_readM_cycles got=%0d exp=5", q_addr.size()); end
    for (int k = 0; k < 5 && k < q_addr.size(); k++) begin
      n_total++; if (q_addr[k] !== exp_a[k]) begin n_bad++; $display("FAIL cold_addr[%0d] got=%h exp=%h", k, q_addr[k], exp_a[k]); end
    end
    model_fill(32'h23);
    m_hits++; m_miss++;
  endtask

  task automatic test_hit_after_fill();
    int lat;
    logic [c_WS-1:0] data;
    run_fetch(16'h0020, lat, data);
    n_total++; if (lat !== 0) begin n_bad++; $display("FAIL hit_latency got=%0d exp=0", lat); end
    n_total++; if (data !== 16'h0000) begin n_bad++; $display("FAIL hit_data got=%h exp=0000", data); end
    n_total++; if (q_addr.size() !== 0) begin n_bad++; $display("FAIL hit_readM_cycles got=%0d exp=0", q_addr.size()); end
    m_hits++;
`ifdef ICACHE_STATS_EN
    n_total++; if (hit_count !== 16'd2) begin n_bad++; $display("FAIL stats_hit got=%0d exp=2", hit_count); end
    n_total++; if (miss_count !== 16'd1) begin n_bad++; $display("FAIL stats_miss got=%0d exp=1", miss_count); end
`endif
    run_fetch(16'h0023, lat, data);
    m_hits++;
    n_total++; if (data !== 16'h6000 || lat !== 0) begin n_bad++; $display("FAIL hit2 got=%h/%0d exp=6000/0", data, lat); end
    @(negedge clk);
    n_total++; if (bus.cpu_ready !== 1'b0) begin n_bad++; $display("FAIL idle_ready got=%b exp=0", bus.cpu_ready); end
    n_total++; if (bus.cpu_rdata !== 16'h6000) begin n_bad++; $display("FAIL rdata_hold got=%h exp=6000", bus.cpu_rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_conflict();
    int lat;
    int refills;
    logic [c_WS-1:0] data;
    refills = 0;
    mem[16'h0000] = 16'h9023;
    run_fetch(16'h0000, lat, data);
    if (lat == 6) refills++;
    n_total++; if (data !== 16'h9023) begin n_bad++; $display("FAIL conflict_first got=%h exp=9023", data); end
    run_fetch(16'h0100, lat, data);
    if (lat == 6) refills++;
    n_total++; if (data !== mem[16'h0100]) begin n_bad++; $display("FAIL conflict_second got=%h exp=%h", data, mem[16'h0100]); end
    run_fetch(16'h0000, lat, data);
    if (lat == 6) refills++;
    n_total++; if (data !== 16'h9023) begin n_bad++; $display("FAIL conflict_last got=%h exp=9023", data); end
    n_total++; if (refills !== 3) begin n_bad++; $display("FAIL conflict_refills got=%0d exp=3", refills); end
    model_fill(32'h0000);
    m_hits += 3; m_miss += 3;
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [c_WS-1:0] data;
    run_fetch(16'h0040, lat, data);
    n_total++; if (lat !== 6) begin n_bad++; $display("FAIL b2b_fill got=%0d exp=6", lat); end
    model_fill(32'h40);
    m_hits++; m_miss++;
    bus.cpu_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.cpu_addr = 16'(16'h0040 + k);
      @(negedge clk);
      n_total++; if (bus.cpu_ready !== 1'b1 || bus.cpu_rdata !== mem[16'h0040 + k]) begin
        n_bad++; $display("FAIL b2b_word%0d got=%b/%h exp=1/%h", k, bus.cpu_ready, bus.cpu_rdata, mem[16'h0040 + k]);
      end
      m_hits++;
      @(posedge clk); #1;
    end
    bus.cpu_req = 1'b0;
  endtask

  task automatic test_flush_fill();
    int lat;
    logic [c_WS-1:0] data;
    q_addr.delete();
    bus.cpu_addr = 16'h0084;
    bus.cpu_req  = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    bus.cpu_flush = 1'b1;
    @(negedge clk);
    n_total++; if (bus.cpu_ready !== 1'b0) begin n_bad++; $display("FAIL flush_fill_ready got=%b exp=0", bus.cpu_ready); end
    @(posedge clk); #1;
    bus.cpu_flush = 1'b0;
    bus.cpu_req   = 1'b0;
    @(negedge clk);
    n_total++; if (bus.i_readM !== 1'b0 || bus.i_address !== 16'h0) begin n_bad++; $display("FAIL flush_fill_idle got=%b/%h exp=0/0000", bus.i_readM, bus.i_address); end
    n_total++; if (q_addr.size() !== 3) begin n_bad++; $display("FAIL flush_fill_reads got=%0d exp=3", q_addr.size()); end
    @(posedge clk); #1;
    model_clear();
    m_miss++;
    run_fetch(16'h0084, lat, data);
    n_total++; if (lat !== 6 || q_addr.size() !== 5) begin n_bad++; $display("FAIL flush_refill got=%0d/%0d exp=6/5", lat, q_addr.size()); end
    n_total++; if (data !== mem[16'h0084]) begin n_bad++; $display("FAIL flush_refill_data got=%h exp=%h", data, mem[16'h0084]); end
    model_fill(32'h84);
    m_hits++; m_miss++;
  endtask

  task automatic test_flush_priority();
    int lat;
    logic [c_WS-1:0] data;
    // hit + flush in the same cycle, then miss + flush
    for (int pass = 0; pass < 2; pass++) begin
      bus.cpu_addr  = 16'h0084;
      bus.cpu_req   = 1'b1;
      bus.cpu_flush = 1'b1;
      @(negedge clk);
      n_total++; if (bus.cpu_ready !== 1'b0) begin n_bad++; $display("FAIL flush_prio%0d_ready got=%b exp=0", pass, bus.cpu_ready); end
      @(posedge clk); #1;
      bus.cpu_flush = 1'b0;
      bus.cpu_req   = 1'b0;
      @(negedge clk);
      n_total++; if (bus.i_readM !== 1'b0) begin n_bad++; $display("FAIL flush_prio%0d_fill got=%b exp=0", pass, bus.i_readM); end
      @(posedge clk); #1;
    end
    model_clear();
    run_fetch(16'h0084, lat, data);
    n_total++; if (lat !== 6) begin n_bad++; $display("FAIL flush_prio_refill got=%0d exp=6", lat); end
    model_fill(32'h84);
    m_hits++; m_miss++;
  endtask

  task automatic test_addr_change();
    int lat;
    logic [c_WS-1:0] data;
    logic [c_WS-1:0] exp_a [10];
    exp_a = '{16'hA0, 16'hA1, 16'hA2, 16'hA3, 16'hA3, 16'hA4, 16'hA5, 16'hA6, 16'hA7, 16'hA7};
    q_addr.delete();
    lat = -1;
    data = '0;
    bus.cpu_addr = 16'h00A0;
    bus.cpu_req  = 1'b1;
    @(posedge clk); #1;
    bus.cpu_addr = 16'h00A4;
    for (int c = 1; c < 40; c++) begin
      @(negedge clk);
      if (bus.cpu_ready === 1'b1) begin lat = c; data = bus.cpu_rdata; break; end
      @(posedge clk); #1;
    end
    if (lat >= 0) begin @(posedge clk); #1; end
    bus.cpu_req = 1'b0;
    n_total++; if (lat !== 12) begin n_bad++; $display("FAIL addr_change_latency got=%0d exp=12", lat); end
    n_total++; if (data !== mem[16'h00A4]) begin n_bad++; $display("FAIL addr_change_data got=%h exp=%h", data, mem[16'h00A4]); end
    n_total++; if (q_addr.size() !== 10) begin n_bad++; $display("FAIL addr_change_reads got=%0d exp=10", q_addr.size()); end
    for (int k = 0; k < 10 && k < q_addr.size(); k++) begin
      n_total++; if (q_addr[k] !== exp_a[k]) begin n_bad++; $display("FAIL addr_change_addr[%0d] got=%h exp=%h", k, q_addr[k], exp_a[k]); end
    end
    model_fill(32'hA0); model_fill(32'hA4);
    m_hits++; m_miss += 2;
    run_fetch(16'h00A2, lat, data);
    n_total++; if (lat !== 0 || data !== mem[16'h00A2]) begin n_bad++; $display("FAIL addr_change_first_line got=%0d/%h exp=0/%h", lat, data, mem[16'h00A2]); end
    m_hits++;
  endtask

  task automatic test_reset_mid_fill();
    int lat;
    logic [c_WS-1:0] data;
    bus.cpu_addr = 16'h00C8;
    bus.cpu_req  = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    #2;
    reset_n = 1'b0;
    #1;
    n_total++; if (bus.i_readM !== 1'b0) begin n_bad++; $display("FAIL rst_fill_readM got=%b exp=0", bus.i_readM); end
    n_total++; if (bus.i_address !== 16'h0) begin n_bad++; $display("FAIL rst_fill_addr got=%h exp=0000", bus.i_address); end
    @(posedge clk); #1;
    reset_n     = 1'b1;
    bus.cpu_req = 1'b0;
    model_clear();
    m_hits = 0; m_miss = 0;
    run_fetch(16'h00C8, lat, data);
    n_total++; if (lat !== 6 || data !== mem[16'h00C8]) begin n_bad++; $display("FAIL rst_fill_refetch got=%0d/%h exp=6/%h", lat, data, mem[16'h00C8]); end
    model_fill(32'hC8);
    m_hits++; m_miss++;
  endtask

  task automatic test_random();
    int unsigned a;
    int unsigned base;
    bit exp_hit;
    int lat;
    logic [c_WS-1:0] data;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.cpu_flush = 1'b1;
        @(posedge clk); #1;
        bus.cpu_flush = 1'b0;
        model_clear();
      end
      a = $urandom_range(0, 127);
      if ($urandom_range(0, 3) == 0) a = a + 32'h0400;
      exp_hit = m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
      run_fetch(16'(a), lat, data);
      n_total++; if (lat !== (exp_hit ? 0 : 6)) begin n_bad++; $display("FAIL rnd_latency a=%h got=%0d exp=%0d", a, lat, exp_hit ? 0 : 6); end
      n_total++; if (data !== mem[a]) begin n_bad++; $display("FAIL rnd_data a=%h got=%h exp=%h", a, data, mem[a]); end
      n_total++; if (q_addr.size() !== (exp_hit ? 0 : 5)) begin n_bad++; $display("FAIL rnd_reads a=%h got=%0d exp=%0d", a, q_addr.size(), exp_hit ? 0 : 5); end
      base = (a / 4) * 4;
      for (int k = 0; k < q_addr.size() && k < 5; k++) begin
        n_total++; if (q_addr[k] !== 16'(base + ((k < 3) ? k : 3))) begin
          n_bad++; $display("FAIL rnd_addr[%0d] got=%h exp=%h", k, q_addr[k], 16'(base + ((k < 3) ? k : 3)));
        end
      end
      model_fill(a);
      m_hits++;
      if (!exp_hit) m_miss++;
    end
    n_total++; if (bus.i_writeM !== 1'b0) begin n_bad++; $display("FAIL writeM got=%b exp=0", bus.i_writeM); end
  endtask

  initial begin
    bus.cpu_req   = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_flush = 1'b0;
    m_hits = 0;
    m_miss = 0;
    model_clear();
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    test_reset();
    test_cold_miss();
    test_hit_after_fill();
    test_conflict();
    test_back_to_back();
    test_flush_fill();
    test_flush_priority();
    test_addr_change();
    test_reset_mid_fill();
    test_random();
`ifdef ICACHE_STATS_EN
    n_total++; if (hit_count !== 16'(m_hits)) begin n_bad++; $display("FAIL final_hit_count got=%0d exp=%0d", hit_count, m_hits); end
    n_total++; if (miss_count !== 16'(m_miss)) begin n_bad++; $display("FAIL final_miss_count got=%0d exp=%0d", miss_count, m_miss); end
`endif
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
